uart_rx: RTL and testbench

UART receiver that is the downstream partner of the UART transmitter. It deserialises the transmitter's `Tx_out` line back into parallel words. The bit period is `PRESCALE` clock cycles, and each bit is sampled at mid-bit. Optional parity is checked, and the stop bit is checked. A one-cycle `Data_valid` pulse is raised for each clean frame, and a one-cycle error pulse is raised for each bad frame. The frame format matches the transmitter: start bit (0), `width` data bits LSB first, optional parity bit, stop bit (1).

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, mid-bit sampling, optional parity and stop checks.
// Define UART_RX_MAJORITY_EN to take a 3-sample majority vote around mid-bit instead of a single sample.
module uart_rx #(
  parameter int width    = 8,
  parameter int PRESCALE = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Rx_in,
  input  logic             Parity_EN,
  input  logic             Parity_type,
  output logic [width-1:0] Data,
  output logic             Data_valid,
  output logic             Parity_error,
  output logic             Stop_error
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (width > 1) ? $clog2(width) : 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_AT = PRESCALE / 2 + 1;
`else
  localparam int SAMPLE_AT = PRESCALE / 2;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [width-1:0]   shift_q, shift_d;
  logic [width-1:0]   data_q, data_d;
  logic               par_en_q, par_en_d;
  logic               par_type_q, par_type_d;
  logic               par_fail_q, par_fail_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               serr_q, serr_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               rx_s;
  logic               bit_s;
  logic               at_sample;
  logic               at_wrap;

  assign rx_s      = sync2_q;
  assign at_sample = (cnt_q == CNT_W'(SAMPLE_AT));
  assign at_wrap   = (cnt_q == CNT_W'(PRESCALE - 1));

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds rx_s from one cycle ago, hist_q[1] from two cycles ago.
  logic [1:0] hist_q, hist_d;
  assign hist_d = {hist_q[0], rx_s};
  assign bit_s  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_s  = rx_s;
`endif

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_fail_q <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      hist_q     <= '1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      par_fail_q <= par_fail_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q     <= hist_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = at_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    par_fail_d = par_fail_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    sync1_d    = Rx_in;
    sync2_d    = sync1_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // The detecting cycle is edge count 0, so the counter resumes at 1.
        if (!rx_s) begin
          state_d    = START;
          cnt_d      = CNT_W'(1);
          idx_d      = '0;
          par_en_d   = Parity_EN;
          par_type_d = Parity_type;
          par_fail_d = 1'b0;
        end
      end
      START: begin
        if (at_sample && bit_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (at_wrap) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (at_sample) shift_d = {bit_s, shift_q[width-1:1]};
        if (at_wrap) begin
          if (idx_q == IDX_W'(width - 1)) state_d = par_en_q ? PARITY : STOP;
          else                            idx_d   = idx_q + IDX_W'(1);
        end
      end
      PARITY: begin
        if (at_sample && (bit_s != ((^shift_q) ^ par_type_q))) par_fail_d = 1'b1;
        if (at_wrap) state_d = STOP;
      end
      STOP: begin
        // Leave at the stop sample so a start edge late in the stop bit is caught.
        if (at_sample) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!bit_s)          serr_d = 1'b1;
          else if (par_fail_q) perr_d = 1'b1;
          else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign Data         = data_q;
  assign Data_valid   = valid_q;
  assign Parity_error = perr_q;
  assign Stop_error   = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames scored against a frame-level model.
module tb_uart_rx;

  localparam int W = 8;
  localparam int P = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_PERR  = 3'b010;
  localparam logic [2:0] K_SERR  = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_in = 1'b1;
  logic         par_en = 1'b0;
  logic         par_type = 1'b0;
  logic [W-1:0] data;
  logic         data_valid;
  logic         parity_error;
  logic         stop_error;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] model_data = 8'h00;

  uart_rx #(.width(W), .PRESCALE(P)) dut (
    .CLK         (clk),
    .Reset       (rst),
    .Rx_in       (rx_in),
    .Parity_EN   (par_en),
    .Parity_type (par_type),
    .Data        (data),
    .Data_valid  (data_valid),
    .Parity_error(parity_error),
    .Stop_error  (stop_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every output pulse must match the oldest pending expectation; an overdue expectation is a miss.
  always @(negedge clk) begin
    if (data_valid || parity_error || stop_error) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({data_valid, parity_error, stop_error}), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("pulse_kind", 32'({data_valid, parity_error, stop_error}), 32'(mon_e.kind));
        check("pulse_data", 32'(data), 32'(mon_e.data));
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
      mon_e = exp_q.pop_front();
      check("missed_pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
    end
  end

  task automatic hold_line(input logic b, input int n_cycles);
    rx_in = b;
    repeat (n_cycles) @(posedge clk);
    #1;
  endtask

  // Builds the frame from the line rules, predicts the outcome and its cycle, then drives it.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                            input bit bad_par, input bit bad_stop);
    exp_t e;
    logic par_bit;
    int   nbits;
    par_bit  = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
    if (ptype) par_bit = ~par_bit;
    if (bad_par) par_bit = ~par_bit;
    nbits    = pen ? W + 2 : W + 1;
    e.cyc    = (cyc + 2) + nbits * P + P / 2 + 1 + MAJ;
    if (bad_stop) begin
      e.kind = K_SERR;
      e.data = model_data;
    end else if (pen && bad_par) begin
      e.kind = K_PERR;
      e.data = model_data;
    end else begin
      e.kind     = K_VALID;
      model_data = d;
      e.data     = d;
    end
    exp_q.push_back(e);
    par_en   = pen;
    par_type = ptype;
    hold_line(1'b0, P);
    par_en   = 1'($urandom);
    par_type = 1'($urandom);
    for (int i = 0; i < W; i++) hold_line(d[i], P);
    if (pen) hold_line(par_bit, P);
    hold_line(~bad_stop, P);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", 32'(data), 32'(0));
    check("reset_valid", 32'(data_valid), 32'(0));
    check("reset_perr", 32'(parity_error), 32'(0));
    check("reset_serr", 32'(stop_error), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold_line(1'b1, 2 * P);

    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    hold_line(1'b1, 2 * P);
    send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 1'b0);
    hold_line(1'b1, 2 * P);
    send_frame(8'hCA, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_line(1'b1, 2 * P);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
    hold_line(1'b1, 2 * P);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
    hold_line(1'b1, 2 * P);

    // Two-cycle low glitch on an idle line.
    hold_line(1'b0, 2);
    hold_line(1'b1, 2 * P);
    send_frame(8'hB7, 1'b0, 1'b0, 1'b0, 1'b0);
    hold_line(1'b1, 2 * P);

    // Reset in the middle of the data bits of a frame that is then abandoned.
    hold_line(1'b0, P);
    hold_line(1'b0, P);
    hold_line(1'b1, P);
    hold_line(1'b0, P / 2);
    rst   = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    model_data = 8'h00;
    @(negedge clk);
    check("midreset_data", 32'(data), 32'(0));
    check("midreset_valid", 32'(data_valid), 32'(0));
    check("midreset_perr", 32'(parity_error), 32'(0));
    check("midreset_serr", 32'(stop_error), 32'(0));
    @(posedge clk);
    #1;
    hold_line(1'b1, 2 * P);
    send_frame(8'hE4, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       pen;
      logic       ptype;
      bit         bad_par;
      bit         bad_stop;
      int         gap;
      d        = 8'($urandom);
      pen      = 1'($urandom);
      ptype    = 1'($urandom);
      bad_par  = ($urandom_range(0, 4) == 0);
      bad_stop = ($urandom_range(0, 9) == 0);
      gap      = bad_stop ? 2 : $urandom_range(0, 2);
      send_frame(d, pen, ptype, bad_par, bad_stop);
      if (gap != 0) hold_line(1'b1, gap * P);
    end

    hold_line(1'b1, 4 * P);
    check("pending_pulses", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
